// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: block geometry, phase codes,
// schedule sigma rotation amounts and a rotate helper.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int NUM_ROUNDS  = 64;

  localparam logic [1:0] PH_LOAD  = 2'b00;
  localparam logic [1:0] PH_RUN   = 2'b01;
  localparam logic [1:0] PH_LAST  = 2'b10;
  localparam logic [1:0] PH_DRAIN = 2'b11;

  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } sched_state_e;

  function automatic logic [WORD_W-1:0] rotr(
    input logic [WORD_W-1:0] x,
    input int                n
  );
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_ssig.sv
// Small-sigma function of the SHA-256 message schedule.
// SEL=0 gives ssig0, SEL=1 gives ssig1.
module sha256_ssig
  import sha256_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam int R1 = (SEL == 0) ? S0_R1 : S1_R1;
  localparam int R2 = (SEL == 0) ? S0_R2 : S1_R2;
  localparam int SH = (SEL == 0) ? S0_SH : S1_SH;

  assign y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads 16 words, then streams
// W0..W63 one per cycle from a 16-word sliding window.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  start_out,
  output logic [1:0]            state_out,
  output logic [5:0]            round_out,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic                  block_done_out
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

  sched_state_e          state;
  logic [3:0]            cnt;
  logic [5:0]            rnd;
  logic [DW-1:0]         dcnt;
  logic [DATA_WIDTH-1:0] win [BLOCK_WORDS];
  logic [DATA_WIDTH-1:0] sig0;
  logic [DATA_WIDTH-1:0] sig1;
  logic [DATA_WIDTH-1:0] wnew;

  sha256_ssig #(.SEL(0)) u_ssig0 (
    .x (win[1]),
    .y (sig0)
  );

  sha256_ssig #(.SEL(1)) u_ssig1 (
    .x (win[14]),
    .y (sig1)
  );

  assign wnew = sig1 + win[9] + sig0 + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      cnt   <= '0;
      rnd   <= '0;
      dcnt  <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++)
        win[i] <= '0;
    end else if (clr_in) begin
      state <= ST_LOAD;
      cnt   <= '0;
      rnd   <= '0;
      dcnt  <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++)
        win[i] <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (in_valid) begin
            win[cnt] <= in_data;
            cnt      <= cnt + 4'd1;
            if (cnt == 4'd15)
              state <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_RUN;
          rnd   <= '0;
        end
        ST_RUN: begin
          for (int i = 0; i < BLOCK_WORDS - 1; i++)
            win[i] <= win[i+1];
          win[BLOCK_WORDS-1] <= wnew;
          // round index holds at 63 through DRAIN
          if (rnd == 6'(NUM_ROUNDS - 1)) begin
            state <= ST_DRAIN;
            dcnt  <= '0;
          end else begin
            rnd <= rnd + 6'd1;
          end
        end
        ST_DRAIN: begin
          if (dcnt == D_LAST) begin
            state <= ST_LOAD;
            cnt   <= '0;
            rnd   <= '0;
            dcnt  <= '0;
            for (int i = 0; i < BLOCK_WORDS; i++)
              win[i] <= '0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    state_out = PH_LOAD;
    unique case (1'b1)
      (state == ST_RUN):
        state_out = (rnd == 6'(NUM_ROUNDS - 1)) ?
                    PH_LAST : PH_RUN;
      (state == ST_DRAIN):
        state_out = PH_DRAIN;
      default:
        state_out = PH_LOAD;
    endcase
  end

  assign in_ready       = (state == ST_LOAD);
  assign start_out      = (state == ST_START);
  assign round_out      = rnd;
  assign w_out          = (state == ST_RUN) ? win[0] : '0;
  assign block_done_out = (state == ST_DRAIN) &&
                          (dcnt == D_LAST);

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message-schedule generator: the transmitter side of the compression core's per-round word input.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
- Then drives, one round per cycle, the W_t word, round index and 2-bit phase code that the compression core consumes.
- Expands W16..W63 on the fly with a 16-entry sliding window; no 64-word storage.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported.
DRAIN_CYCLES, 8, cycles spent in DRAIN after round 63, covering the downstream serial digest output, before the next block is accepted.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clr_in  input  1  synchronous soft clear; aborts any block, returns to LOAD
in_valid  input  1  in_data holds a valid message word
in_ready  output  1  block can accept a word; high only in LOAD
in_data  input  DATA_WIDTH  message word; first accepted word is W0
start_out  output  1  one-cycle pulse telling the core to load initial hash values
state_out  output  2  phase code: 00 LOAD/START, 01 RUN (rounds 0..62), 10 LAST (round 63), 11 DRAIN
round_out  output  6  current round index t
w_out  output  DATA_WIDTH  W_t for round_out
block_done_out  output  1  one-cycle pulse on the final DRAIN cycle

Behaviour:
- Internal states: LOAD, START, RUN, DRAIN. state_out is 00 in LOAD and START, 01/10 in RUN (10 when round = 63), 11 in DRAIN.
- Reset values: state LOAD, word counter 0, window all 0, round 0, drain counter 0. in_ready=1 (combinational, state==LOAD). start_out=0, state_out=00, round_out=0, w_out=0, block_done_out=0.
- LOAD: a word is accepted when in_valid&&in_ready. It is written to win[cnt] and cnt is incremented. When the 16th word is accepted (cnt==15), go to START next cycle. A stalled in_valid simply holds cnt.
- START (exactly 1 cycle): start_out=1, state_out=00, in_ready=0. Next state RUN with round=0.
- RUN (64 cycles):
  - w_out=win[0], round_out=t.
  - Each cycle, win shifts down by one (win[i]<=win[i+1]) and win[15]<=ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], mod 2^32.
  - ssig0(x)=ROTR7^ROTR18^SHR3; ssig1(x)=ROTR17^ROTR19^SHR10.
  - After round 63, go to DRAIN; round_out is not wrapped to 0 and holds 63.
- Latency: first-word accept to round 0 = 16 accept cycles + 1 START cycle. Block occupancy = 16 + 1 + 64 + DRAIN_CYCLES cycles minimum.
- DRAIN: w_out=0, round_out=63, state_out=11, in_ready=0. The drain counter runs 0..DRAIN_CYCLES-1. On the last count, block_done_out=1, then LOAD with cnt=0 and window cleared.
- w_out is 0 outside RUN.
- clr_in:
  - In any state, clr_in forces LOAD next cycle, cnt=0, window cleared, and all outputs at their reset values.
  - clr_in wins over a simultaneous word accept; that word is dropped, and in_ready stays 1 so the producer sees it accepted.
  - clr_in during START suppresses RUN entry.
- Async reset mid-RUN: immediate return to reset values. No partial outputs afterwards.
- Rounds advance every cycle with no downstream backpressure; the core accepts one word per cycle.

Decomposition:
- Shared package sha256_pkg:
  - WORD_W=32, BLOCK_WORDS=16, NUM_ROUNDS=64.
  - Phase codes PH_LOAD=2'b00, PH_RUN=2'b01, PH_LAST=2'b10, PH_DRAIN=2'b11.
  - Rotation amounts for ssig0/ssig1.
- One combinational sub-module, sha256_ssig, with parameter SEL (0→ssig0, 1→ssig1). It is instantiated twice.

Test Plan:
- "abc" block (W0=61626380, W1..W14=0, W15=00000018):
  - start_out pulses 1 cycle after the 16th accept.
  - Round 0: w_out=61626380. Round 15: w_out=00000018.
  - Round 16: 61626380. Round 17: 000F0000.
  - Round 63 matches the software model, with state_out=10 on that cycle only.
- Gapped in_valid (one word every 3 cycles): identical W sequence. in_ready drops only after START is entered.
- Back-to-back blocks, DRAIN_CYCLES=8:
  - in_ready=0 for exactly 1+64+8 cycles after the 16th accept.
  - block_done_out pulses once per block, and the second block's W0 is not corrupted by the first block's window.
- clr_in asserted at round 30: next cycle state_out=00, round_out=0, w_out=0, in_ready=1. A fresh block then produces correct W_t.
- clr_in together with an accept at word 7: that word is dropped and cnt returns to 0. A subsequent full 16-word load is correct.
- rst_n asserted asynchronously mid-RUN: outputs go to reset values without a clock edge. After release, in_ready=1 and start_out=0.
